// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared definitions for the seven-segment scan controller.
//   SEG_OFF      - all segments dark (active-low bus)
//   scan_state_t - controller state (OFF until the first commit, then SCAN)
//   lead_digit() - index of the most significant nonzero nibble (0 if all zero)
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    OFF,
    SCAN
  } scan_state_t;

  // Fixed 8-nibble loop so the bound stays static; n limits the digits examined.
  function automatic int unsigned lead_digit(input logic [31:0] value,
                                             input int unsigned n);
    int unsigned lead;
    lead = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < n && value[i*4 +: 4] != 4'h0) lead = i;
    end
    return lead;
  endfunction

endpackage

// File: rtl/seven_seg.sv
// seven_seg: hex nibble to seven-segment decoder.
//   nibble - 4-bit hex value
//   seg    - segment lines, active-low, ordered gfedcba
module seven_seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    unique case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan controller for common-anode
// seven-segment digits sharing one segment bus. A new value is taken through
// a valid/ready handshake into a pending buffer and copied to the displayed
// (active) buffer only on frame boundaries.
//   clk, rst     - clock, synchronous active-high reset
//   value_in     - packed nibbles, digit 0 (rightmost) in [3:0]
//   value_valid  - offer value_in
//   value_ready  - pending buffer empty
//   blank        - force display dark (scanning continues)
//   seg_out      - segment lines, active-low, gfedcba
//   an_out       - digit enables, active-low, one-hot
//   frame_done   - one-cycle pulse after the last digit's slot ends
// Build option: define SEVEN_SEG_LZB_EN for leading-zero blanking.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic                    blank,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);
  import seven_seg_pkg::*;

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  scan_state_t            state, state_n;
  logic [DIV_W-1:0]       div_cnt, div_cnt_n;
  logic [IDX_W-1:0]       idx, idx_n;
  logic [VAL_W-1:0]       pending, pending_n;
  logic                   pending_v, pending_v_n;
  logic [VAL_W-1:0]       active, active_n;
  logic [6:0]             seg_q, seg_n;
  logic [NUM_DIGITS-1:0]  an_q, an_n;
  logic                   frame_done_q, frame_done_n;

  logic                   tick, boundary, commit;
  logic [3:0]             cur_nibble;
  logic [6:0]             cur_seg;

  assign tick       = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign boundary   = tick && (idx == IDX_W'(NUM_DIGITS - 1));
  assign cur_nibble = active[idx*4 +: 4];

  seven_seg u_dec (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= OFF;
      div_cnt      <= '0;
      idx          <= '0;
      pending      <= '0;
      pending_v    <= 1'b0;
      active       <= '0;
      seg_q        <= SEG_OFF;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_n;
      div_cnt      <= div_cnt_n;
      idx          <= idx_n;
      pending      <= pending_n;
      pending_v    <= pending_v_n;
      active       <= active_n;
      seg_q        <= seg_n;
      an_q         <= an_n;
      frame_done_q <= frame_done_n;
    end
  end

  always_comb begin
    state_n      = state;
    div_cnt_n    = tick ? '0 : div_cnt + 1'b1;
    idx_n        = idx;
    pending_n    = pending;
    pending_v_n  = pending_v;
    active_n     = active;
    seg_n        = SEG_OFF;
    an_n         = '1;
    frame_done_n = boundary;
    commit       = 1'b0;

    if (tick) idx_n = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;

    // OFF commits as soon as something is pending; SCAN waits for the boundary.
    if (pending_v && (state == OFF || boundary)) commit = 1'b1;

    if (commit) begin
      active_n    = pending;
      pending_v_n = 1'b0;
      state_n     = SCAN;
    end

    // Ready is low whenever pending_v is set, so accept and commit never coincide.
    if (value_valid && !pending_v) begin
      pending_n   = value_in;
      pending_v_n = 1'b1;
    end

    if (state == SCAN && !blank) begin
      an_n  = ~(NUM_DIGITS'(1) << idx);
      seg_n = cur_seg;
`ifdef SEVEN_SEG_LZB_EN
      if (32'(idx) > lead_digit(32'(active), NUM_DIGITS)) seg_n = SEG_OFF;
`endif
    end
  end

  assign value_ready = !pending_v;
  assign seg_out     = seg_q;
  assign an_out      = an_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: self-checking bench for seven_seg_scan_ctrl with
// NUM_DIGITS=4, SCAN_DIV=4, using a cycle-count based reference model.
module tb_seven_seg_scan_ctrl;

  localparam int N = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_in = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic        blank = 1'b0;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .blank       (blank),
    .seg_out     (seg_out),
    .an_out      (an_out),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [6:0] ref_seg(input logic [15:0] v, input int d);
    logic [15:0] upper;
    upper = v >> (4 * d);
`ifdef SEVEN_SEG_LZB_EN
    if (d > 0 && upper == 16'h0) return 7'h7F;
`endif
    return hex_seg(upper[3:0]);
  endfunction

  int          m_cyc;
  logic        m_on, m_pend_v, m_fd;
  logic [15:0] m_pend, m_active;
  logic [6:0]  m_seg;
  logic [3:0]  m_an;
  int          m_dig;
  logic        m_bound, m_commit, m_ready;

  // Position within a frame follows directly from cycles since reset.
  assign m_dig    = (m_cyc / D) % N;
  assign m_bound  = (m_cyc % (N * D)) == (N * D - 1);
  assign m_commit = m_pend_v && (!m_on || m_bound);
  assign m_ready  = !m_pend_v;

  always @(posedge clk) begin
    if (rst) begin
      m_cyc <= 0; m_on <= 1'b0; m_pend_v <= 1'b0; m_pend <= '0; m_active <= '0;
      m_seg <= 7'h7F; m_an <= 4'hF; m_fd <= 1'b0;
    end else begin
      m_fd <= m_bound;
      if (!m_on || blank) begin
        m_seg <= 7'h7F; m_an <= 4'hF;
      end else begin
        m_seg <= ref_seg(m_active, m_dig);
        m_an  <= ~(4'b0001 << m_dig);
      end
      if (m_commit) begin
        m_active <= m_pend; m_on <= 1'b1;
      end
      if (value_valid && !m_pend_v) begin
        m_pend <= value_in; m_pend_v <= 1'b1;
      end else if (m_commit) begin
        m_pend_v <= 1'b0;
      end
      m_cyc <= m_cyc + 1;
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; value_valid = 1'b0; blank = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (seg_out !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h expected 7f", seg_out); end
    n_checks++; if (an_out !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %b expected 1111", an_out); end
    n_checks++; if (value_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", value_ready); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
    rst = 1'b0;
  endtask

  task automatic test_load_off;
    logic [6:0] exp_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    bit found;
    @(negedge clk);
    value_in = 16'h1234; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    n_checks++; if (value_ready !== 1'b0) begin n_fail++; $display("FAIL off_ready_low: got %b expected 0", value_ready); end
    @(negedge clk);
    n_checks++; if (value_ready !== 1'b1) begin n_fail++; $display("FAIL off_ready_high: got %b expected 1", value_ready); end
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (frame_done === 1'b1) found = 1;
      @(negedge clk);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL off_wait_fd: got timeout expected frame_done"); end
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (an_out !== ~(4'b0001 << (k / 4)) || seg_out !== exp_seg[k / 4]) begin
        n_fail++;
        $display("FAIL scan_1234[%0d]: got an=%b seg=%b expected an=%b seg=%b",
                 k, an_out, seg_out, ~(4'b0001 << (k / 4)), exp_seg[k / 4]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_update_mid_frame;
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (an_out === 4'b1101) found = 1; else @(negedge clk);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL mid_wait_digit1: got timeout expected an=1101"); end
    value_in = 16'hABCD; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      n_checks++;
      if ({seg_out, an_out, value_ready, frame_done} !== {m_seg, m_an, m_ready, m_fd}) begin
        n_fail++;
        $display("FAIL mid_model: got seg=%b an=%b rdy=%b fd=%b expected seg=%b an=%b rdy=%b fd=%b",
                 seg_out, an_out, value_ready, frame_done, m_seg, m_an, m_ready, m_fd);
      end
      if (value_ready === 1'b1) found = 1; else @(negedge clk);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL mid_wait_ready: got timeout expected ready"); end
    n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL mid_fd_with_ready: got %b expected 1", frame_done); end
    @(negedge clk);
    n_checks++;
    if (an_out !== 4'b1110 || seg_out !== 7'b0100001) begin
      n_fail++; $display("FAIL mid_new_digit0: got an=%b seg=%b expected an=1110 seg=0100001", an_out, seg_out);
    end
  endtask

  task automatic test_blank;
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (an_out === 4'b1101) found = 1; else @(negedge clk);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL blank_wait: got timeout expected an=1101"); end
    blank = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (seg_out !== 7'h7F || an_out !== 4'hF) begin
        n_fail++; $display("FAIL blank_dark[%0d]: got seg=%b an=%b expected seg=1111111 an=1111", k, seg_out, an_out);
      end
    end
    blank = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if ({seg_out, an_out, frame_done} !== {m_seg, m_an, m_fd}) begin
        n_fail++; $display("FAIL blank_release[%0d]: got seg=%b an=%b expected seg=%b an=%b", k, seg_out, an_out, m_seg, m_an);
      end
    end
  endtask

  task automatic test_lzb;
    logic [6:0] exp_seg [4];
    bit found;
`ifdef SEVEN_SEG_LZB_EN
    exp_seg = '{7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111};
`else
    exp_seg = '{7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000};
`endif
    value_in = 16'h0050; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (value_ready === 1'b1 && frame_done === 1'b1) found = 1; else @(negedge clk);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL lzb_wait_commit: got timeout expected ready+fd"); end
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (an_out !== ~(4'b0001 << (k / 4)) || seg_out !== exp_seg[k / 4]) begin
        n_fail++;
        $display("FAIL lzb_0050[%0d]: got an=%b seg=%b expected an=%b seg=%b",
                 k, an_out, seg_out, ~(4'b0001 << (k / 4)), exp_seg[k / 4]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_pending;
    logic [15:0] v;
    value_in = 16'h9999; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    n_checks++; if (value_ready !== 1'b0) begin n_fail++; $display("FAIL rp_pending: got %b expected 0", value_ready); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({seg_out, an_out, value_ready, frame_done} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL rp_reset_values: got seg=%b an=%b rdy=%b fd=%b expected 1111111 1111 1 0",
                         seg_out, an_out, value_ready, frame_done);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (seg_out !== 7'h7F || an_out !== 4'hF || value_ready !== 1'b1) begin
        n_fail++; $display("FAIL rp_stays_off[%0d]: got seg=%b an=%b rdy=%b expected 1111111 1111 1", k, seg_out, an_out, value_ready);
      end
    end
    v = 16'($urandom);
    value_in = v; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if ({seg_out, an_out, value_ready, frame_done} !== {m_seg, m_an, m_ready, m_fd}) begin
        n_fail++; $display("FAIL rp_reload[%0d]: got seg=%b an=%b rdy=%b fd=%b expected seg=%b an=%b rdy=%b fd=%b",
                           k, seg_out, an_out, value_ready, frame_done, m_seg, m_an, m_ready, m_fd);
      end
    end
  endtask

  task automatic test_random(input int cycles, input bit back_to_back);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      n_checks++;
      if ({seg_out, an_out, value_ready, frame_done} !== {m_seg, m_an, m_ready, m_fd}) begin
        n_fail++; $display("FAIL random[%0d]: got seg=%b an=%b rdy=%b fd=%b expected seg=%b an=%b rdy=%b fd=%b",
                           k, seg_out, an_out, value_ready, frame_done, m_seg, m_an, m_ready, m_fd);
      end
      value_in    = 16'($urandom);
      value_valid = back_to_back ? 1'b1 : ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) blank = ~blank;
    end
    value_valid = 1'b0;
    blank = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_off();
    test_update_mid_frame();
    test_blank();
    test_lzb();
    test_reset_pending();
    test_random(300, 1'b0);
    test_random(100, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode seven-segment digits that share one segment bus. It accepts a packed hex value through a valid/ready handshake and double-buffers it so updates land only on frame boundaries. It strobes one digit at a time at a programmable rate and drives the shared segment lines through a single `seven_seg` decoder instance. It sits between the filter's status/result registers and the board display pins.

## Interface

Parameters:
- `NUM_DIGITS`, default 4: number of digits scanned (2..8).
- `SCAN_DIV`, default 50000: clock cycles each digit is lit (≥2).

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `value_in`, in, 4*NUM_DIGITS: packed nibbles. Digit 0 = `value_in[3:0]`, which is the rightmost digit.
- `value_valid`, in, 1: offer `value_in`.
- `value_ready`, out, 1: pending buffer empty, so a new value can be accepted.
- `blank`, in, 1: force display dark. Scanning continues while dark.
- `seg_out`, out, 7: segment lines, active-low, gfedcba.
- `an_out`, out, NUM_DIGITS: digit enables, active-low, one-hot.
- `frame_done`, out, 1: one-cycle pulse when the last digit's slot ends.

## Operation

- State machine with two states:
  - OFF (after reset): `an_out` is all ones.
  - SCAN: entered on the first commit and never left except by reset.
- **Handshake:**
  - Accept when `value_valid && value_ready`. The value goes into the pending register and `pending_v` is set.
  - `value_ready = !pending_v`.
  - `value_in` is ignored when not accepted.
- **Commit:** pending is copied to the active register and `pending_v` is cleared.
  - In OFF, commit happens the cycle after accept and the state moves to SCAN.
  - In SCAN, commit happens only on the frame boundary cycle (`tick && idx == NUM_DIGITS-1`).
  - An accept on the boundary cycle itself commits at the next boundary.
- **Scan counters:**
  - `div_cnt` counts 0..SCAN_DIV-1 and `tick = (div_cnt == SCAN_DIV-1)`.
  - `idx` increments on `tick` and wraps from NUM_DIGITS-1 to 0.
  - Both counters run in all states.
- **Outputs** are registered from `idx`, the active register, and `blank`:
  - `an_out` = ~(1<<idx).
  - `seg_out` = decode(active nibble `idx`).
  - When `blank` is high or the state is OFF: `an_out` and `seg_out` are all ones.
- `frame_done` is high on the cycle after the boundary cycle. It pulses in OFF as well.
- **Reset values:** `seg_out` = 7'h7F, `an_out` = all ones, `value_ready` = 1, `frame_done` = 0, `idx` = 0, `div_cnt` = 0, active = 0, `pending_v` = 0.
- A reset mid-operation discards pending and active contents.

## Timing

- Accept to `value_ready` high again:
  - In OFF: 1 cycle.
  - In SCAN: up to NUM_DIGITS*SCAN_DIV cycles.
- `idx`/active change to `seg_out`/`an_out` change: 1 cycle.
- Each digit is lit for exactly SCAN_DIV cycles. A frame is NUM_DIGITS*SCAN_DIV cycles.
- `blank` takes effect 1 cycle after assertion and releases 1 cycle after deassertion.

## Configuration

- `SEVEN_SEG_LZB_EN` defined: leading-zero blanking.
  - A digit above the most significant nonzero nibble of the active value outputs `seg_out` = 7'h7F. Its anode is still strobed.
  - Digit 0 is always shown, so value 0 displays "0".
- `SEVEN_SEG_LZB_EN` undefined: all digits are decoded, including leading zeros.

## Structure

- Shared package `seven_seg_pkg`:
  - `SEG_OFF` = 7'h7F.
  - State enum `scan_state_t` {OFF, SCAN}.
  - Function for the leading-digit index.
- Sub-module: one `seven_seg` instance, whose input is the active nibble selected by `idx`. The decoder is not duplicated per digit.

## Test plan

All scenarios use NUM_DIGITS=4 and SCAN_DIV=4.

1. Reset: hold `rst` 2 cycles → `seg_out` = 7'h7F, `an_out` = 4'b1111, `value_ready` = 1, `frame_done` = 0.
2. Load 16'h1234 in OFF → `value_ready` is low for 1 cycle and the state becomes SCAN. Then `an_out` cycles 1110/1101/1011/0111 with `seg_out` 0011001/0110000/0100100/1111001, each held 4 cycles.
3. Load 16'hABCD while digit 1 is lit → `value_ready` stays low and the old digits continue through digit 3. Then `frame_done` pulses, `value_ready` rises, and digit 0 shows 0100001.
4. Assert `blank` for 6 cycles mid-frame → outputs are all ones 1 cycle later. After release, `idx` has advanced as if unblanked.
5. With `SEVEN_SEG_LZB_EN`, load 16'h0050 → digits 3 and 2 output 1111111, digit 1 outputs 0010010, digit 0 outputs 1000000. Without the macro, digits 3 and 2 output 1000000.
6. Accept 16'h9999 with a value pending, then assert `rst` → all reset values restored. No value appears until a new load is accepted.
